// File: rtl/clk_step_ctrl_if.sv
// Core-side signals of the run/step/halt controller.
// master: halt request and divider write; receives cpu_ce, state and ce_toggle.
// slave: the controller side.
interface clk_step_ctrl_if #(
  parameter int CNT_W = 26
);
  logic             halt_req;
  logic             div_wr;
  logic [CNT_W-1:0] div_data;
  logic             cpu_ce;
  logic [1:0]       state;
  logic             ce_toggle;

  modport master (
    output halt_req, div_wr, div_data,
    input  cpu_ce, state, ce_toggle
  );

  modport slave (
    input  halt_req, div_wr, div_data,
    output cpu_ce, state, ce_toggle
  );
endinterface

// File: rtl/clk_step_ctrl.sv
// Run/step/halt controller producing a single-cycle core clock-enable on clk_in.
// Ports: clk_in, rst_n (async, active low), mode_run and step_btn (async board inputs),
// bus: halt_req, div_wr/div_data in; cpu_ce, state, ce_toggle out.
module clk_step_ctrl #(
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 25_000_000,
  parameter int DEB_CYCLES  = 500_000
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          mode_run,
  input  logic          step_btn,
  clk_step_ctrl_if.slave bus
);
  localparam int               DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_e;

  logic             run_meta_q, run_s_q;
  logic             step_meta_q, step_s_q;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             deb_level_q, deb_level_d;
  logic             step_pulse;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] rate_cnt_q, rate_cnt_d;
  logic [CNT_W-1:0] eff_div_m1;
  logic             tick;
  state_e           state_q, state_d;
  logic             cpu_ce_q, cpu_ce_d;
  logic             ce_toggle_q, ce_toggle_d;

  // Counter runs while the synchronized input disagrees with the accepted level;
  // any return to the accepted level restarts it, so only a stable change is taken.
  always_comb begin
    deb_cnt_d   = deb_cnt_q;
    deb_level_d = deb_level_q;
    step_pulse  = 1'b0;
    if (step_s_q == deb_level_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_cnt_d   = '0;
      deb_level_d = step_s_q;
      step_pulse  = step_s_q;
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end
  end

  always_comb begin
    eff_div_m1 = (div_q == '0) ? '0 : div_q - CNT_W'(1);
    tick       = (rate_cnt_q >= eff_div_m1);
    div_d      = bus.div_wr ? bus.div_data : div_q;
  end

  always_comb begin
    state_d    = state_q;
    cpu_ce_d   = 1'b0;
    rate_cnt_d = '0;
    case (state_q)
      ST_HALT: begin
        if (step_pulse) begin
          state_d  = ST_STEP;
          cpu_ce_d = 1'b1;
        end else if (run_s_q && !bus.halt_req) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.halt_req) begin
          state_d = ST_BREAK;
        end else if (!run_s_q) begin
          state_d = ST_HALT;
        end else begin
          rate_cnt_d = tick ? '0 : rate_cnt_q + CNT_W'(1);
          cpu_ce_d   = tick;
        end
      end
      ST_STEP: state_d = ST_HALT;
      ST_BREAK: begin
        if (!run_s_q) state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
    ce_toggle_d = ce_toggle_q ^ cpu_ce_d;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      run_meta_q  <= 1'b0;
      run_s_q     <= 1'b0;
      step_meta_q <= 1'b0;
      step_s_q    <= 1'b0;
      deb_cnt_q   <= '0;
      deb_level_q <= 1'b0;
      div_q       <= DIV_RST;
      rate_cnt_q  <= '0;
      state_q     <= ST_HALT;
      cpu_ce_q    <= 1'b0;
      ce_toggle_q <= 1'b0;
    end else begin
      run_meta_q  <= mode_run;
      run_s_q     <= run_meta_q;
      step_meta_q <= step_btn;
      step_s_q    <= step_meta_q;
      deb_cnt_q   <= deb_cnt_d;
      deb_level_q <= deb_level_d;
      div_q       <= div_d;
      rate_cnt_q  <= rate_cnt_d;
      state_q     <= state_d;
      cpu_ce_q    <= cpu_ce_d;
      ce_toggle_q <= ce_toggle_d;
    end
  end

  assign bus.cpu_ce    = cpu_ce_q;
  assign bus.state     = state_q;
  assign bus.ce_toggle = ce_toggle_q;
endmodule

// File: tb/tb_clk_step_ctrl.sv
module tb_clk_step_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic mode_run;
  logic step_btn;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;

  clk_step_ctrl_if #(.CNT_W(8)) bus ();

  clk_step_ctrl #(
    .CNT_W(8),
    .DEFAULT_DIV(5),
    .DEB_CYCLES(4)
  ) dut (
    .clk_in(clk),
    .rst_n(rst_n),
    .mode_run(mode_run),
    .step_btn(step_btn),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic       tog;
    logic [1:0] st;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int at, input logic tog, input logic [1:0] st);
    exp_t e;
    e.at = at; e.tog = tog; e.st = st;
    sb.push_back(e);
  endtask

  task automatic step_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: every cpu_ce pulse must match the oldest expected pulse.
  always @(negedge clk) begin
    if (bus.cpu_ce === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_ce: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ce_cycle", cyc, e.at);
        chk("ce_toggle", {31'b0, bus.ce_toggle}, {31'b0, e.tog});
        chk("ce_state", {30'b0, bus.state}, {30'b0, e.st});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int c0, c1, e, c2, f, g, s, r;
    rst_n        = 1'b0;
    mode_run     = 1'b0;
    step_btn     = 1'b0;
    bus.halt_req = 1'b0;
    bus.div_wr   = 1'b0;
    bus.div_data = '0;

    @(negedge clk);
    chk("rst_state", {30'b0, bus.state}, 0);
    chk("rst_ce", {31'b0, bus.cpu_ce}, 0);
    chk("rst_tog", {31'b0, bus.ce_toggle}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Free run at default divide of 5.
    @(negedge clk);
    c0 = cyc;
    mode_run = 1'b1;
    push(c0 + 8, 1'b1, 2'b01);
    push(c0 + 13, 1'b0, 2'b01);
    push(c0 + 18, 1'b1, 2'b01);
    step_to(c0 + 2);  chk("run_lat_pre", {30'b0, bus.state}, 0);
    step_to(c0 + 3);  chk("run_lat", {30'b0, bus.state}, 1);

    // Run switch off while counter is 2: tick suppressed, back to HALT.
    step_to(c0 + 18); mode_run = 1'b0;
    step_to(c0 + 20); chk("run_off_pre", {30'b0, bus.state}, 1);
    step_to(c0 + 21); chk("run_off", {30'b0, bus.state}, 0);

    // Re-entry restarts the count.
    c1 = c0 + 23;
    step_to(c1); mode_run = 1'b1;
    e = c1 + 3;
    push(e + 5, 1'b0, 2'b01);
    step_to(e); chk("rerun", {30'b0, bus.state}, 1);

    // Divider 2 written while counter is 3.
    step_to(e + 8); bus.div_wr = 1'b1; bus.div_data = 8'd2;
    push(e + 10, 1'b1, 2'b01);
    push(e + 12, 1'b0, 2'b01);
    push(e + 14, 1'b1, 2'b01);
    step_to(e + 9); bus.div_wr = 1'b0;

    // Divider 0 behaves as 1: enable every cycle.
    step_to(e + 14); bus.div_wr = 1'b1; bus.div_data = 8'd0;
    push(e + 16, 1'b0, 2'b01);
    push(e + 17, 1'b1, 2'b01);
    push(e + 18, 1'b0, 2'b01);
    step_to(e + 15); bus.div_wr = 1'b0;

    // Asynchronous reset during a high cpu_ce cycle.
    step_to(e + 18);
    #2 rst_n = 1'b0;
    mode_run = 1'b0;
    #1;
    chk("arst_ce", {31'b0, bus.cpu_ce}, 0);
    chk("arst_state", {30'b0, bus.state}, 0);
    chk("arst_tog", {31'b0, bus.ce_toggle}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Divider back at 5 after reset; then breakpoint on counter 4.
    @(negedge clk);
    c2 = cyc;
    mode_run = 1'b1;
    f = c2 + 3;
    push(f + 5, 1'b1, 2'b01);
    push(f + 10, 1'b0, 2'b01);
    step_to(f); chk("run2", {30'b0, bus.state}, 1);
    step_to(f + 14); bus.halt_req = 1'b1;
    step_to(f + 15); bus.halt_req = 1'b0;
    chk("brk_state", {30'b0, bus.state}, 3);
    chk("brk_ce", {31'b0, bus.cpu_ce}, 0);

    // Step press in BREAK is ignored.
    step_to(f + 16); step_btn = 1'b1;
    step_to(f + 28); step_btn = 1'b0;
    step_to(f + 38); chk("brk_hold", {30'b0, bus.state}, 3);
    g = f + 38;
    mode_run = 1'b0;
    step_to(g + 2); chk("brk_ack_pre", {30'b0, bus.state}, 3);
    step_to(g + 3); chk("brk_ack", {30'b0, bus.state}, 0);
    step_to(g + 6); chk("no_queued_step", {30'b0, bus.state}, 0);

    // Bouncy press in HALT: one step.
    s = g + 8;
    step_to(s);     step_btn = 1'b1;
    step_to(s + 1); step_btn = 1'b0;
    step_to(s + 2); step_btn = 1'b1;
    push(s + 8, 1'b1, 2'b10);
    step_to(s + 7); chk("step_pre", {30'b0, bus.state}, 0);
    step_to(s + 8); chk("step_state", {30'b0, bus.state}, 2);
    step_to(s + 9); chk("step_done", {30'b0, bus.state}, 0);
    step_to(s + 12); step_btn = 1'b0;

    // Release then re-press: second step.
    r = s + 20;
    step_to(r); step_btn = 1'b1;
    push(r + 6, 1'b0, 2'b10);
    step_to(r + 6); chk("step2_state", {30'b0, bus.state}, 2);
    step_to(r + 7); chk("step2_done", {30'b0, bus.state}, 0);
    step_to(r + 10); step_btn = 1'b0;

    step_to(r + 12);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
